// File: rtl/ram_rd_trig.sv
// ram_rd_trig: follows the sample RAM write pointer at a fixed lag, detects a
// level-crossing trigger and streams DISP_LEN consecutive samples per frame.
module ram_rd_trig #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 12,
  parameter int DISP_LEN     = 640,
  parameter int LAG          = 4,
  parameter int HOLDOFF      = 1024,
  parameter int AUTO_TIMEOUT = 2048
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] ram_wr_addr_i,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [DATA_W-1:0] ram_rd_data_i,
  input  logic [DATA_W-1:0] trig_level_i,
  input  logic              trig_edge_i,
  input  logic              auto_mode_i,
  input  logic              frame_req_i,
  output logic              busy_o,
  output logic              samp_valid_o,
  output logic [DATA_W-1:0] samp_data_o,
  output logic [ADDR_W-1:0] samp_index_o,
  output logic              samp_first_o,
  output logic              frame_done_o,
  output logic              trig_timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
  localparam int HO_W = $clog2(HOLDOFF + 1);
  localparam logic [ADDR_W-1:0] LAG_C    = ADDR_W'(LAG);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DISP_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(AUTO_TIMEOUT - 1);
  localparam logic [HO_W-1:0]   HO_LAST  = HO_W'(HOLDOFF);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                rd_en_q, rd_vld_q;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [HO_W-1:0]     ho_cnt_q, ho_cnt_d;
  logic                busy_q;
  logic                samp_valid_q, samp_valid_d;
  logic [DATA_W-1:0]   samp_data_q, samp_data_d;
  logic [ADDR_W-1:0]   samp_index_q, samp_index_d;
  logic                samp_first_q, samp_first_d;
  logic                frame_done_q, frame_done_d;
  logic                trig_to_q, trig_to_d;
  logic                cross_s, force_s;
  logic [ADDR_W-1:0]   nxt_idx_s;

  // next-state, trigger compare and sample-stream decode
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q | (frame_req_i && (state_q != S_IDLE));
    prev_d       = prev_q;
    prev_vld_d   = prev_vld_q;
    to_cnt_d     = to_cnt_q;
    ho_cnt_d     = ho_cnt_q;
    samp_valid_d = 1'b0;
    samp_data_d  = samp_data_q;
    samp_index_d = samp_index_q;
    samp_first_d = 1'b0;
    frame_done_d = 1'b0;
    trig_to_d    = trig_to_q;
    nxt_idx_s    = samp_index_q + ADDR_W'(1);
    // equal-to-level on the previous sample never counts as a crossing
    if (trig_edge_i) begin
      cross_s = prev_vld_q && (prev_q > trig_level_i) && (ram_rd_data_i <= trig_level_i);
    end else begin
      cross_s = prev_vld_q && (prev_q < trig_level_i) && (ram_rd_data_i >= trig_level_i);
    end
    force_s = auto_mode_i && (to_cnt_q == TO_LAST);

    case (state_q)
      S_IDLE: begin
        if (frame_req_i || pend_q) begin
          state_d    = S_ARM;
          pend_d     = 1'b0;
          prev_vld_d = 1'b0;
          to_cnt_d   = '0;
          trig_to_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM: begin
        if (to_cnt_q != TO_LAST) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
          to_cnt_d = to_cnt_q;
        end
        if (rd_vld_q) begin
          prev_d     = ram_rd_data_i;
          prev_vld_d = 1'b1;
          if (cross_s || force_s) begin
            state_d      = S_CAPTURE;
            samp_valid_d = 1'b1;
            samp_data_d  = ram_rd_data_i;
            samp_index_d = '0;
            samp_first_d = 1'b1;
            trig_to_d    = ~cross_s;
          end else begin
            state_d = S_ARM;
          end
        end else begin
          state_d = S_ARM;
        end
      end
      S_CAPTURE: begin
        if (rd_vld_q) begin
          samp_valid_d = 1'b1;
          samp_data_d  = ram_rd_data_i;
          samp_index_d = nxt_idx_s;
          if (nxt_idx_s == LAST_IDX) begin
            frame_done_d = 1'b1;
            state_d      = S_HOLDOFF;
            ho_cnt_d     = '0;
          end else begin
            state_d = S_CAPTURE;
          end
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_HOLDOFF: begin
        if (ho_cnt_q == HO_LAST) begin
          state_d = S_IDLE;
        end else begin
          ho_cnt_d = ho_cnt_q + HO_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state, pipeline and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      rd_vld_q     <= 1'b0;
      pend_q       <= 1'b0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      to_cnt_q     <= '0;
      ho_cnt_q     <= '0;
      busy_q       <= 1'b0;
      samp_valid_q <= 1'b0;
      samp_data_q  <= '0;
      samp_index_q <= '0;
      samp_first_q <= 1'b0;
      frame_done_q <= 1'b0;
      trig_to_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= ram_wr_addr_i - LAG_C;
      rd_en_q      <= (state_d == S_ARM) || (state_d == S_CAPTURE);
      rd_vld_q     <= rd_en_q;
      pend_q       <= pend_d;
      prev_q       <= prev_d;
      prev_vld_q   <= prev_vld_d;
      to_cnt_q     <= to_cnt_d;
      ho_cnt_q     <= ho_cnt_d;
      busy_q       <= (state_d != S_IDLE);
      samp_valid_q <= samp_valid_d;
      samp_data_q  <= samp_data_d;
      samp_index_q <= samp_index_d;
      samp_first_q <= samp_first_d;
      frame_done_q <= frame_done_d;
      trig_to_q    <= trig_to_d;
    end
  end

  assign ram_rd_en_o    = rd_en_q;
  assign ram_rd_addr_o  = rd_addr_q;
  assign busy_o         = busy_q;
  assign samp_valid_o   = samp_valid_q;
  assign samp_data_o    = samp_data_q;
  assign samp_index_o   = samp_index_q;
  assign samp_first_o   = samp_first_q;
  assign frame_done_o   = frame_done_q;
  assign trig_timeout_o = trig_to_q;

endmodule

// File: tb/tb_ram_rd_trig.sv
// Bench for ram_rd_trig: sample RAM + writer model, per-scenario tasks and a
// list-based trigger model over the data stream the RAM returned.
module tb_ram_rd_trig;
  localparam int ADDR_W = 10, DATA_W = 12, DISP_LEN = 640, LAG = 4;
  localparam int HOLDOFF = 1024, AUTO_TIMEOUT = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, ram_rd_en, trig_edge, auto_mode, frame_req;
  logic              busy, samp_valid, samp_first, frame_done, trig_timeout;
  logic [ADDR_W-1:0] ram_wr_addr = '0;
  logic [ADDR_W-1:0] ram_rd_addr, samp_index;
  logic [DATA_W-1:0] ram_rd_data = '0;
  logic [DATA_W-1:0] trig_level, samp_data;

  ram_rd_trig #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DISP_LEN(DISP_LEN), .LAG(LAG),
                .HOLDOFF(HOLDOFF), .AUTO_TIMEOUT(AUTO_TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .ram_wr_addr_i(ram_wr_addr), .ram_rd_en_o(ram_rd_en),
    .ram_rd_addr_o(ram_rd_addr), .ram_rd_data_i(ram_rd_data), .trig_level_i(trig_level),
    .trig_edge_i(trig_edge), .auto_mode_i(auto_mode), .frame_req_i(frame_req),
    .busy_o(busy), .samp_valid_o(samp_valid), .samp_data_o(samp_data),
    .samp_index_o(samp_index), .samp_first_o(samp_first), .frame_done_o(frame_done),
    .trig_timeout_o(trig_timeout));

  int checks = 0, failures = 0;
  int mode = 0, wcnt = 0;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  function automatic logic [DATA_W-1:0] gen(input int m, input int n);
    case (m)
      0:       return DATA_W'((n * 8) % 4096);
      1:       return DATA_W'(4095 - (n * 8) % 4096);
      2:       return DATA_W'(500);
      3:       return DATA_W'(2 * (n % 1024));
      default: return DATA_W'($urandom_range(0, 4095));
    endcase
  endfunction

  // continuous writer and synchronous-read sample RAM
  always @(posedge clk) begin
    mem[ram_wr_addr] <= gen(mode, wcnt);
    wcnt <= wcnt + 1;
    ram_wr_addr <= ram_wr_addr + 1'b1;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  // record what the RAM returned during each read-enabled burst
  int  stream[$];
  logic en_d1 = 1'b0;
  time en_rise_t = 0;
  always @(negedge clk) begin
    if (en_d1) stream.push_back(int'(ram_rd_data));
    if (ram_rd_en && !en_d1) begin
      stream.delete();
      en_rise_t = $time;
    end
    en_d1 = ram_rd_en;
  end

  int  cap_data[$];
  int  cap_bad;
  bit  cap_tmo;
  time cap_t0;

  task automatic pulse_req();
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
  endtask

  task automatic capture(input int budget, output bit got);
    int n = 0;
    cap_data.delete();
    cap_bad = 0;
    cap_tmo = 1'b0;
    got = 1'b0;
    @(negedge clk);
    while (!samp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (samp_valid) begin
      cap_t0 = $time;
      for (int k = 0; k < DISP_LEN; k++) begin
        if (!samp_valid || samp_index !== ADDR_W'(k) || samp_first !== (k == 0) ||
            frame_done !== (k == DISP_LEN - 1)) cap_bad++;
        cap_data.push_back(int'(samp_data));
        if (k == DISP_LEN - 1) cap_tmo = trig_timeout;
        else @(negedge clk);
      end
      got = 1'b1;
    end
  endtask

  // first stream position that satisfies the trigger rules, or the forced one
  function automatic int model_start(output bit forced);
    forced = 1'b0;
    for (int j = 0; j < stream.size(); j++) begin
      if (j > 0) begin
        if (!trig_edge && stream[j-1] < int'(trig_level) && stream[j] >= int'(trig_level)) return j;
        if (trig_edge && stream[j-1] > int'(trig_level) && stream[j] <= int'(trig_level)) return j;
      end
      if (auto_mode && j == AUTO_TIMEOUT - 2) begin
        forced = 1'b1;
        return j;
      end
    end
    return -1;
  endfunction

  function automatic int frame_errs(input int start);
    int e = 0;
    if (start < 0 || cap_data.size() != DISP_LEN) return DISP_LEN;
    for (int k = 0; k < DISP_LEN; k++)
      if (start + k >= stream.size() || cap_data[k] != stream[start + k]) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; frame_req = 1'b0; trig_level = '0; trig_edge = 1'b0; auto_mode = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_rd_en, ram_rd_addr, busy, samp_valid, samp_data, samp_index, samp_first,
         frame_done, trig_timeout} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b valid=%b rd_en=%b rd_addr=%0d, want all 0",
               busy, samp_valid, ram_rd_en, ram_rd_addr);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ram_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req: got busy=%b rd_en=%b want 0 0", busy, ram_rd_en);
    end
  endtask

  task automatic test_ramp();
    bit got, f; int e, st;
    mode = 0; trig_level = 12'd1000; trig_edge = 1'b0; auto_mode = 1'b0;
    repeat (20) @(negedge clk);
    pulse_req();
    capture(3000, got);
    e = 0;
    for (int k = 0; k < cap_data.size(); k++) if (cap_data[k] != (1000 + 8 * k) % 4096) e++;
    st = model_start(f);
    checks++;
    if (!got || cap_bad != 0 || cap_data.size() != DISP_LEN) begin
      failures++; $display("FAIL ramp_frame: got=%0d bad=%0d want got=1 bad=0", got, cap_bad);
    end
    checks++;
    if (e != 0) begin failures++; $display("FAIL ramp_values: got %0d errors want 0", e); end
    checks++;
    if (frame_errs(st) != 0 || cap_tmo !== 1'b0) begin
      failures++; $display("FAIL ramp_model: got errs=%0d tmo=%b want 0 0", frame_errs(st), cap_tmo);
    end
    @(negedge clk);
    checks++;
    if (samp_valid !== 1'b0) begin failures++; $display("FAIL ramp_valid_after: got %b want 0", samp_valid); end
    repeat (HOLDOFF - 1) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL holdoff_busy: got %b want 1", busy); end
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL holdoff_end: got busy=%b want 0", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL req_at_expiry: got busy=%b want 1", busy); end
    capture(3000, got);
    st = model_start(f);
    checks++;
    if (!got || cap_bad != 0 || frame_errs(st) != 0 || cap_data[0] != 1000) begin
      failures++; $display("FAIL expiry_frame: got=%0d bad=%0d errs=%0d want 1 0 0", got, cap_bad, frame_errs(st));
    end
    repeat (HOLDOFF + 10) @(negedge clk);
  endtask

  task automatic test_falling();
    bit got, f; int st;
    mode = 1; trig_level = 12'd2048; trig_edge = 1'b1; auto_mode = 1'b0;
    repeat (20) @(negedge clk);
    pulse_req();
    capture(3000, got);
    st = model_start(f);
    checks++;
    if (!got || cap_bad != 0 || cap_data[0] != 2047) begin
      failures++; $display("FAIL falling_first: got=%0d bad=%0d want first 2047", got, cap_bad);
    end
    checks++;
    if (frame_errs(st) != 0 || cap_tmo !== 1'b0) begin
      failures++; $display("FAIL falling_model: got errs=%0d tmo=%b want 0 0", frame_errs(st), cap_tmo);
    end
    repeat (HOLDOFF + 10) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL falling_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_auto_timeout();
    bit got, f; int st, nv;
    mode = 2; trig_level = 12'd1000; trig_edge = 1'b0; auto_mode = 1'b1;
    repeat (20) @(negedge clk);
    pulse_req();
    capture(AUTO_TIMEOUT + 200, got);
    st = model_start(f);
    checks++;
    if (!got || cap_bad != 0 || frame_errs(st) != 0 || cap_data[0] != 500) begin
      failures++; $display("FAIL auto_frame: got=%0d bad=%0d errs=%0d want 1 0 0", got, cap_bad, frame_errs(st));
    end
    checks++;
    if (cap_tmo !== 1'b1) begin failures++; $display("FAIL auto_tmo_flag: got %b want 1", cap_tmo); end
    checks++;
    if ((cap_t0 - en_rise_t) / 10 != AUTO_TIMEOUT) begin
      failures++; $display("FAIL auto_latency: got %0d want %0d", (cap_t0 - en_rise_t) / 10, AUTO_TIMEOUT);
    end
    repeat (HOLDOFF + 10) @(negedge clk);
    auto_mode = 1'b0;
    pulse_req();
    nv = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (samp_valid) nv++;
    end
    checks++;
    if (nv != 0 || busy !== 1'b1) begin
      failures++; $display("FAIL no_auto_wait: got valids=%0d busy=%b want 0 1", nv, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || ram_rd_en !== 1'b0) begin
      failures++; $display("FAIL arm_reset: got busy=%b rd_en=%b want 0 0", busy, ram_rd_en);
    end
  endtask

  task automatic test_wrap();
    bit got, f; int st, n = 0;
    mode = 3; trig_level = 12'd1000; trig_edge = 1'b1; auto_mode = 1'b0;
    while (ram_wr_addr != 10'd2 && n < 1100) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (ram_rd_addr !== 10'd1022) begin
      failures++; $display("FAIL rd_addr_wrap: got %0d want 1022", ram_rd_addr);
    end
    repeat (20) @(negedge clk);
    pulse_req();
    capture(1500, got);
    st = model_start(f);
    checks++;
    if (!got || cap_bad != 0 || cap_data[0] != 0 || cap_data[1] != 2 || frame_errs(st) != 0) begin
      failures++; $display("FAIL wrap_frame: got=%0d bad=%0d errs=%0d want 1 0 0", got, cap_bad, frame_errs(st));
    end
    repeat (HOLDOFF + 10) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit g1, g2, f; int st, n = 0, nb = 0, e1;
    mode = 0; trig_level = DATA_W'(8 * $urandom_range(40, 480)); trig_edge = 1'b0; auto_mode = 1'b0;
    repeat (20) @(negedge clk);
    pulse_req();
    fork
      capture(3000, g1);
      begin
        while (!(samp_valid && samp_index == 10'd100) && n < 3000) begin @(negedge clk); n++; end
        pulse_req();
        repeat (5) @(negedge clk);
        pulse_req();
      end
    join
    st = model_start(f);
    e1 = frame_errs(st);
    capture(HOLDOFF + 3000, g2);
    st = model_start(f);
    checks++;
    if (!g1 || !g2 || e1 != 0 || frame_errs(st) != 0 || cap_bad != 0) begin
      failures++; $display("FAIL pending_frames: got g1=%0d g2=%0d errs=%0d/%0d want 1 1 0 0", g1, g2, e1, frame_errs(st));
    end
    repeat (HOLDOFF + 10) @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    checks++;
    if (nb != 0) begin failures++; $display("FAIL pending_merged: got %0d busy cycles want 0", nb); end
  endtask

  task automatic test_reset_mid();
    bit got, f; int st, n = 0, nd = 0;
    mode = 0; trig_level = 12'd1000; trig_edge = 1'b0; auto_mode = 1'b0;
    repeat (20) @(negedge clk);
    pulse_req();
    while (!(samp_valid && samp_index == 10'd300) && n < 3000) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ram_rd_en, ram_rd_addr, busy, samp_valid, samp_data, samp_index, samp_first,
         frame_done, trig_timeout} !== '0) begin
      failures++; $display("FAIL mid_reset: got busy=%b valid=%b idx=%0d data=%0d want all 0",
                           busy, samp_valid, samp_index, samp_data);
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy || frame_done || samp_valid) nd++;
    end
    checks++;
    if (nd != 0) begin failures++; $display("FAIL post_reset_idle: got %0d active cycles want 0", nd); end
    pulse_req();
    capture(3000, got);
    st = model_start(f);
    checks++;
    if (!got || cap_bad != 0 || frame_errs(st) != 0 || cap_data[0] != 1000) begin
      failures++; $display("FAIL post_reset_frame: got=%0d bad=%0d errs=%0d want 1 0 0", got, cap_bad, frame_errs(st));
    end
    repeat (HOLDOFF + 10) @(negedge clk);
  endtask

  task automatic test_random();
    bit got, f; int st;
    for (int r = 0; r < 3; r++) begin
      mode = 4;
      trig_level = DATA_W'($urandom_range(500, 3500));
      trig_edge = 1'($urandom_range(0, 1));
      auto_mode = 1'($urandom_range(0, 1));
      repeat (20) @(negedge clk);
      pulse_req();
      capture(AUTO_TIMEOUT + 1500, got);
      st = model_start(f);
      checks++;
      if (!got || cap_bad != 0 || frame_errs(st) != 0 || cap_tmo !== f) begin
        failures++; $display("FAIL random_frame%0d: got=%0d bad=%0d errs=%0d tmo=%b want 1 0 0 %b",
                             r, got, cap_bad, frame_errs(st), cap_tmo, f);
      end
      repeat (HOLDOFF + 10) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL random_idle%0d: got busy=%b want 0", r, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_falling();
    test_auto_timeout();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
